// File: rtl/sm_ram_loader_if.sv
// RAM write port between the loader (master) and the data RAM (slave).
// The master holds addr/data stable while wr_req is high until wr_ack.
interface sm_ram_loader_if #(
    parameter int ADDR_W = 4
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/sm_ram_loader.sv
// Key-driven word assembler: shifts switch nibbles into a 32-bit preview and
// writes it to a switch-selected RAM word over a req/ack handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | accepting load/commit presses, wr_req low
//   ST_REQ  | write request held until wr_ack, presses discarded
module sm_ram_loader #(
    parameter int DEBOUNCE_MAX = 250000,
    parameter int CNT_W        = 18,
    parameter int ADDR_W       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_key_load_n,
    input  logic                i_key_commit_n,
    input  logic [3:0]          i_sw_nibble,
    input  logic [ADDR_W-1:0]   i_sw_addr,
    sm_ram_loader_if.master     wr,
    output logic [31:0]         o_preview,
    output logic [3:0]          o_nibble_cnt,
    output logic                o_busy
);

    localparam int                KEY_LOAD   = 0;
    localparam int                KEY_COMMIT = 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_MAX - 1);
    localparam logic [3:0]        NIB_FULL   = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    logic [1:0]        w_key_raw;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_deb;
    logic [1:0]        r_deb_d;
    logic [CNT_W-1:0]  r_deb_cnt [2];
    logic [1:0]        w_press;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_preview;
    logic [31:0]       w_preview_nxt;
    logic [3:0]        r_nibble_cnt;
    logic [3:0]        w_nibble_cnt_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [31:0]       r_wr_data;
    logic [31:0]       w_wr_data_nxt;

    assign w_key_raw = {i_key_commit_n, i_key_load_n};

    // Keys are active-low; everything resets to "released" so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1      <= 2'b11;
            r_sync2      <= 2'b11;
            r_deb        <= 2'b11;
            r_deb_d      <= 2'b11;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == CNT_LAST) begin
                    r_deb[k]     <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb_d & ~r_deb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_preview    <= '0;
            r_nibble_cnt <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_preview    <= w_preview_nxt;
            r_nibble_cnt <= w_nibble_cnt_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_preview_nxt    = r_preview;
        w_nibble_cnt_nxt = r_nibble_cnt;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        case (r_state)
            ST_IDLE: begin
                // Commit takes priority over a load press arriving in the same cycle.
                if (w_press[KEY_COMMIT]) begin
                    w_state_nxt   = ST_REQ;
                    w_wr_addr_nxt = i_sw_addr;
                    w_wr_data_nxt = r_preview;
                end else if (w_press[KEY_LOAD]) begin
                    w_preview_nxt    = {r_preview[27:0], i_sw_nibble};
                    w_nibble_cnt_nxt = (r_nibble_cnt == NIB_FULL) ? NIB_FULL
                                                                  : r_nibble_cnt + 4'd1;
                end
            end
            ST_REQ: begin
                if (wr.wr_ack) begin
                    w_state_nxt      = ST_IDLE;
                    w_preview_nxt    = '0;
                    w_nibble_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wr.wr_req    = (r_state == ST_REQ);
    assign wr.wr_addr   = r_wr_addr;
    assign wr.wr_data   = r_wr_data;
    assign o_busy       = (r_state == ST_REQ);
    assign o_preview    = r_preview;
    assign o_nibble_cnt = r_nibble_cnt;

endmodule
